// File: rtl/updn_ctr_lim_if.sv
// Signal bundle for the limited up/down counter: control/config inputs and counter status outputs.
interface updn_ctr_lim_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             cen;
  logic             up_dn;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] lo_lim;
  logic [WIDTH-1:0] hi_lim;
  logic             mode;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tercnt;
  logic             wrapped;
  logic             ovf_sticky;
  logic             cfg_err;

  // No handshake: every control input is sampled on each rising clk edge,
  // status outputs are valid continuously (count/wrapped/ovf_sticky registered).
  modport master (
    output load, data, cen, up_dn, step, lo_lim, hi_lim, mode, clr_ovf,
    input  count, tercnt, wrapped, ovf_sticky, cfg_err
  );

  modport slave (
    input  load, data, cen, up_dn, step, lo_lim, hi_lim, mode, clr_ovf,
    output count, tercnt, wrapped, ovf_sticky, cfg_err
  );
endinterface

// File: rtl/updn_ctr_lim.sv
// Up/down counter with programmable limits and step, wrap-or-saturate at the
// bounds, a registered wrap pulse and a sticky saturation flag.
module updn_ctr_lim #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          reset,
  updn_ctr_lim_if.slave bus
);
  logic [WIDTH-1:0] count_q;
  logic             wrapped_q;
  logic             ovf_q;

  // One extra bit keeps the carry of count+step so an overflow past 2^WIDTH
  // is seen as a crossing rather than a small in-range value.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             up_ok;
  logic             dn_ok;
  logic             cfg_err;
  logic             step_en;
  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             sat_evt;

  assign cfg_err = bus.lo_lim > bus.hi_lim;
  assign sum     = {1'b0, count_q} + {1'b0, bus.step};
  assign diff    = {1'b0, count_q} - {1'b0, bus.step};
  assign up_ok   = sum <= {1'b0, bus.hi_lim};
  assign dn_ok   = (count_q >= bus.step) && (diff >= {1'b0, bus.lo_lim});
  assign step_en = bus.cen && !bus.load && !cfg_err && (bus.step != '0);

  always_comb begin
    next_count = count_q;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    if (step_en) begin
      if (bus.up_dn) begin
        if (up_ok) begin
          next_count = sum[WIDTH-1:0];
        end else if (bus.mode) begin
          next_count = bus.hi_lim;
          sat_evt    = 1'b1;
        end else begin
          next_count = bus.lo_lim;
          wrap_evt   = 1'b1;
        end
      end else begin
        if (dn_ok) begin
          next_count = diff[WIDTH-1:0];
        end else if (bus.mode) begin
          next_count = bus.lo_lim;
          sat_evt    = 1'b1;
        end else begin
          next_count = bus.hi_lim;
          wrap_evt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= RST_VAL;
      wrapped_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (bus.load) begin
        count_q   <= bus.data;
        wrapped_q <= 1'b0;
      end else begin
        count_q   <= next_count;
        wrapped_q <= wrap_evt;
      end
      // A saturation on the same edge as clr_ovf keeps the flag set.
      ovf_q <= sat_evt | (ovf_q & ~bus.clr_ovf);
    end
  end

  assign bus.count      = count_q;
  assign bus.wrapped    = wrapped_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.cfg_err    = cfg_err;
  assign bus.tercnt     = (bus.up_dn && (count_q == bus.hi_lim)) ||
                          (!bus.up_dn && (count_q == bus.lo_lim));
endmodule
